// File: rtl/mem_dump_reader.sv
// BRAM read-back engine: walks a word-aligned address range and streams each word on valid/ready.
// Optional running word sum on the stream is built only when DUMP_CHECKSUM_EN is defined.
module mem_dump_reader #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_rd_enb,
  input  logic [DATA_WIDTH-1:0]  mem_rd_dat,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic [ADDR_WIDTH-1:0]  m_addr,
  output logic                   m_last,
  output logic [DATA_WIDTH-1:0]  checksum
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, SEND, DONE} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic                   mem_rd_enb_q, mem_rd_enb_d;
  logic                   m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
  logic [ADDR_WIDTH-1:0]  m_addr_q, m_addr_d;
  logic                   m_last_q, m_last_d;

  logic handshake;
  logic accept_start;
  logic unused_base_lsbs;

  assign handshake        = m_valid_q & m_ready;
  assign accept_start     = (state_q == IDLE) & start;
  assign unused_base_lsbs = ^base_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_rd_enb_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_addr_q     <= '0;
      m_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_enb_q <= mem_rd_enb_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_addr_q     <= m_addr_d;
      m_last_q     <= m_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            state_d     = ISSUE;
            addr_d      = {base_addr[ADDR_WIDTH-1:2], 2'b00};
            remaining_d = word_count;
          end else begin
            state_d = DONE;
          end
        end
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = SEND;
      SEND: begin
        if (handshake) begin
          if (m_last_q) begin
            state_d = DONE;
          end else begin
            // Address counter wraps silently at the top of the BRAM.
            addr_d      = addr_q + ADDR_WIDTH'(4);
            remaining_d = remaining_q - COUNT_WIDTH'(1);
            state_d     = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    busy_d       = (state_d == ISSUE) || (state_d == CAPTURE) || (state_d == SEND);
    done_d       = (state_d == DONE);
    mem_rd_enb_d = (state_d == ISSUE);
    mem_addr_d   = mem_rd_enb_d ? addr_d : mem_addr_q;
    m_valid_d    = (state_d == SEND);
    m_data_d     = m_data_q;
    m_addr_d     = m_addr_q;
    m_last_d     = m_last_q;
    if (state_q == CAPTURE) begin
      m_data_d = mem_rd_dat;
      m_addr_d = addr_q;
      m_last_d = (remaining_q == COUNT_WIDTH'(1));
    end
  end

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (accept_start) begin
      checksum_d = '0;
    end else if (handshake) begin
      checksum_d = checksum_q + m_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  logic unused_accept_start;
  assign unused_accept_start = accept_start;
  assign checksum            = '0;
`endif

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rd_enb = mem_rd_enb_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_addr     = m_addr_q;
  assign m_last     = m_last_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Scoreboard bench for mem_dump_reader: expected beats are queued by the stimulus and
// popped by an independent stream monitor; a small behavioural BRAM serves the reads.
module tb_mem_dump_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] base_addr;
  logic [10:0] word_count;
  logic        busy;
  logic        done;
  logic [11:0] mem_addr;
  logic        mem_rd_enb;
  logic [31:0] mem_rd_dat;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [11:0] m_addr;
  logic        m_last;
  logic [31:0] checksum;

  typedef struct {
    logic [31:0] data;
    logic [11:0] addr;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] mem [0:1023];
  int          checks;
  int          errors;
  int          done_cnt;
  int          beat_cnt;
  logic        exp_done_next;
  logic        prev_hs;

  mem_dump_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_rd_enb (mem_rd_enb),
    .mem_rd_dat (mem_rd_dat),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_addr     (m_addr),
    .m_last     (m_last),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_enb) mem_rd_dat <= mem[mem_addr[11:2]];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] ckExp(input logic [31:0] sum);
`ifdef DUMP_CHECKSUM_EN
    return sum;
`else
    return 32'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushBeat(input logic [31:0] d, input logic [11:0] a, input logic l);
    beat_t b;
    b.data = d;
    b.addr = a;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // One-cycle start; inputs are then scrambled to show they are not re-sampled.
  task automatic applyStimulus(input logic [11:0] b, input logic [10:0] c);
    start      = 1'b1;
    base_addr  = b;
    word_count = c;
    tick();
    start      = 1'b0;
    base_addr  = 12'h3A7;
    word_count = 11'd5;
  endtask

  task automatic waitValid(input string name);
    int n;
    n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput({name, "_valid_timeout"}, {31'd0, m_valid}, 32'd1);
  endtask

  task automatic waitDone(input int prev, input string name);
    int n;
    n = 0;
    while (done_cnt == prev && n < 100) begin
      tick();
      n++;
    end
    checkOutput({name, "_done_timeout"}, {31'd0, done_cnt != prev}, 32'd1);
    repeat (3) tick();
    checkOutput({name, "_done_once"}, done_cnt - prev, 32'd1);
    checkOutput({name, "_queue_drained"}, exp_q.size(), 32'd0);
  endtask

  // Stream monitor: every valid cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_hs       = 1'b0;
      exp_done_next = 1'b0;
    end else begin
      if (exp_done_next) begin
        checkOutput("done_after_last", {31'd0, done}, 32'd1);
        exp_done_next = 1'b0;
      end
      if (prev_hs) checkOutput("valid_drop", {31'd0, m_valid}, 32'd0);
      if (done) done_cnt++;
      if (mem_rd_enb) begin
        checkOutput("mem_addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
        checkOutput("rd_enb_busy", {31'd0, busy}, 32'd1);
      end
      prev_hs = m_valid && m_ready;
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got data 0x%0h addr 0x%0h, expected none", m_data, m_addr);
        end else begin
          checkOutput("beat_data", m_data, exp_q[0].data);
          checkOutput("beat_addr", {20'd0, m_addr}, {20'd0, exp_q[0].addr});
          checkOutput("beat_last", {31'd0, m_last}, {31'd0, exp_q[0].last});
          if (m_ready) begin
            if (exp_q[0].last) exp_done_next = 1'b1;
            void'(exp_q.pop_front());
            beat_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int prev_done;
    int prev_beats;
    logic saw_activity;

    checks        = 0;
    errors        = 0;
    done_cnt      = 0;
    beat_cnt      = 0;
    exp_done_next = 1'b0;
    prev_hs       = 1'b0;
    rst           = 1'b1;
    start         = 1'b0;
    base_addr     = '0;
    word_count    = '0;
    m_ready       = 1'b0;
    mem_rd_dat    = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'd5;
    mem[1] = 32'd0;
    mem[2] = 32'd1;
    mem[3] = 32'd1;

    repeat (3) tick();
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_mem_addr", {20'd0, mem_addr}, 32'd0);
    checkOutput("reset_rd_enb", {31'd0, mem_rd_enb}, 32'd0);
    checkOutput("reset_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("reset_m_data", m_data, 32'd0);
    checkOutput("reset_m_addr", {20'd0, m_addr}, 32'd0);
    checkOutput("reset_m_last", {31'd0, m_last}, 32'd0);
    checkOutput("reset_checksum", checksum, 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] test 1: four-word dump from 0x0");
    m_ready = 1'b1;
    pushBeat(32'd5, 12'h000, 1'b0);
    pushBeat(32'd0, 12'h004, 1'b0);
    pushBeat(32'd1, 12'h008, 1'b0);
    pushBeat(32'd1, 12'h00C, 1'b1);
    prev_done  = done_cnt;
    prev_beats = beat_cnt;
    applyStimulus(12'h000, 11'd4);
    checkOutput("t1_rd_enb_n1", {31'd0, mem_rd_enb}, 32'd1);
    checkOutput("t1_busy_n1", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("t1_valid_n2", {31'd0, m_valid}, 32'd0);
    tick();
    checkOutput("t1_valid_n3", {31'd0, m_valid}, 32'd1);
    waitDone(prev_done, "t1");
    checkOutput("t1_beats", beat_cnt - prev_beats, 32'd4);
    checkOutput("t1_checksum", checksum, ckExp(32'd7));
    checkOutput("t1_idle_busy", {31'd0, busy}, 32'd0);

    $display("[TB] test 2: backpressure on first beat");
    m_ready = 1'b0;
    pushBeat(32'd0, 12'h004, 1'b0);
    pushBeat(32'd1, 12'h008, 1'b1);
    prev_done = done_cnt;
    applyStimulus(12'h004, 11'd2);
    waitValid("t2");
    for (int i = 0; i < 5; i++) begin
      checkOutput("t2_hold_valid", {31'd0, m_valid}, 32'd1);
      checkOutput("t2_hold_data", m_data, 32'd0);
      checkOutput("t2_hold_addr", {20'd0, m_addr}, 32'h004);
      tick();
    end
    m_ready = 1'b1;
    waitDone(prev_done, "t2");
    checkOutput("t2_checksum", checksum, ckExp(32'd1));

    $display("[TB] test 3: zero-length dump");
    prev_done  = done_cnt;
    prev_beats = beat_cnt;
    applyStimulus(12'h010, 11'd0);
    checkOutput("t3_done_n1", {31'd0, done}, 32'd1);
    checkOutput("t3_busy_n1", {31'd0, busy}, 32'd0);
    saw_activity = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (m_valid || mem_rd_enb || busy) saw_activity = 1'b1;
      tick();
    end
    checkOutput("t3_no_activity", {31'd0, saw_activity}, 32'd0);
    checkOutput("t3_done_once", done_cnt - prev_done, 32'd1);
    checkOutput("t3_no_beats", beat_cnt - prev_beats, 32'd0);
    checkOutput("t3_checksum", checksum, 32'd0);

    $display("[TB] test 4: unaligned base wrapping past 0xFFC");
    mem[1023] = 32'hDEADBEEF;
    pushBeat(32'hDEADBEEF, 12'hFFC, 1'b0);
    pushBeat(32'd5, 12'h000, 1'b1);
    prev_done = done_cnt;
    applyStimulus(12'hFFE, 11'd2);
    checkOutput("t4_mem_addr", {20'd0, mem_addr}, 32'hFFC);
    waitDone(prev_done, "t4");
    checkOutput("t4_checksum", checksum, ckExp(32'hDEADBEF4));

    $display("[TB] test 5: reset after first beat");
    pushBeat(32'd5, 12'h000, 1'b0);
    pushBeat(32'd0, 12'h004, 1'b0);
    pushBeat(32'd1, 12'h008, 1'b0);
    pushBeat(32'd1, 12'h00C, 1'b1);
    applyStimulus(12'h000, 11'd4);
    waitValid("t5");
    tick();
    rst = 1'b1;
    exp_q.delete();
    prev_done = done_cnt;
    tick();
    rst = 1'b0;
    checkOutput("t5_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("t5_rst_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("t5_rst_rd_enb", {31'd0, mem_rd_enb}, 32'd0);
    checkOutput("t5_rst_m_data", m_data, 32'd0);
    checkOutput("t5_rst_checksum", checksum, 32'd0);
    repeat (4) tick();
    checkOutput("t5_no_done", done_cnt - prev_done, 32'd0);
    pushBeat(32'd1, 12'h008, 1'b1);
    prev_beats = beat_cnt;
    applyStimulus(12'h008, 11'd1);
    checkOutput("t5_mem_addr", {20'd0, mem_addr}, 32'h008);
    waitDone(prev_done, "t5");
    checkOutput("t5_beats", beat_cnt - prev_beats, 32'd1);
    checkOutput("t5_checksum", checksum, ckExp(32'd1));

    $display("[TB] test 6: start pulses while busy are ignored");
    pushBeat(32'd5, 12'h000, 1'b0);
    pushBeat(32'd0, 12'h004, 1'b0);
    pushBeat(32'd1, 12'h008, 1'b0);
    pushBeat(32'd1, 12'h00C, 1'b1);
    prev_done  = done_cnt;
    prev_beats = beat_cnt;
    applyStimulus(12'h000, 11'd4);
    start      = 1'b1;
    base_addr  = 12'h100;
    word_count = 11'd2;
    tick();
    start = 1'b0;
    waitValid("t6");
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(prev_done, "t6");
    checkOutput("t6_beats", beat_cnt - prev_beats, 32'd4);
    checkOutput("t6_checksum", checksum, ckExp(32'd7));
    checkOutput("t6_idle_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
